trng_osc_sampler: RTL and testbench

//  Control and sampling stage for an array of osc_cell ring-oscillator entropy cells.

---
 rtl/trng_osc_sampler.sv | 146 ++++++++++++++
 tb/tb_trng_osc_sampler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/trng_osc_sampler.sv
// Sequences ring-oscillator entropy cells through reset/free-run phases, samples and XOR-folds
// their outputs, packs bits into words and guards the stream with a repetition-count test.
module trng_osc_sampler #(
    parameter int N_CELLS   = 4,
    parameter int WORD_W    = 32,
    parameter int RST_CYC   = 4,
    parameter int OSC_CYC   = 16,
    parameter int REP_LIMIT = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [N_CELLS-1:0] osc_in,
    output logic               cell_t,
    output logic               cell_i1,
    output logic               cell_i2,
    output logic [WORD_W-1:0]  rnd_data,
    output logic               rnd_valid,
    input  logic               rnd_ready,
    output logic               health_fail
);

    localparam int CNT_MAX = (RST_CYC > OSC_CYC) ? RST_CYC : OSC_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(WORD_W + 1);
    localparam int REP_W   = $clog2(REP_LIMIT + 1);

    typedef enum logic [2:0] {IDLE, CRST, RUN, SAMP, HOLD} state_t;

    state_t             state;
    logic [N_CELLS-1:0] osc_m;
    logic [N_CELLS-1:0] osc_s;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WORD_W-1:0]  sh;
    logic [REP_W-1:0]   rep_cnt;
    logic               last_bit;
    logic               raw_bit;
    logic [REP_W-1:0]   rep_next;
    logic               word_done;

    // Oscillator outputs are asynchronous; two flops before any use.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            osc_m <= '0;
            osc_s <= '0;
        end else begin
            osc_m <= osc_in;
            osc_s <= osc_m;
        end
    end

    always_comb begin
        raw_bit   = ^osc_s;
        rep_next  = (rep_cnt != '0 && raw_bit == last_bit) ? rep_cnt + REP_W'(1) : REP_W'(1);
        word_done = (bit_cnt == BIT_W'(WORD_W - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            sh          <= '0;
            rep_cnt     <= '0;
            last_bit    <= 1'b0;
            cell_t      <= 1'b0;
            cell_i1     <= 1'b0;
            cell_i2     <= 1'b0;
            rnd_data    <= '0;
            rnd_valid   <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            cell_i2 <= 1'b0;
            // Dropping en mid-word abandons the partial word; the repetition history survives.
            if (!en && (state == CRST || state == RUN || state == SAMP)) begin
                state   <= IDLE;
                cnt     <= '0;
                bit_cnt <= '0;
                sh      <= '0;
                cell_t  <= 1'b0;
                cell_i1 <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (en && !health_fail) begin
                            state <= CRST;
                            cnt   <= '0;
                        end
                    end
                    CRST: begin
                        if (cnt == CNT_W'(RST_CYC - 1)) begin
                            state   <= RUN;
                            cnt     <= '0;
                            cell_t  <= 1'b1;
                            cell_i1 <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        if (cnt == CNT_W'(OSC_CYC - 1)) begin
                            state <= SAMP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    SAMP: begin
                        rep_cnt  <= rep_next;
                        last_bit <= raw_bit;
                        cell_t   <= 1'b0;
                        cell_i1  <= 1'b0;
                        cnt      <= '0;
                        // A health failure outranks a completed word.
                        if (rep_next >= REP_W'(REP_LIMIT)) begin
                            health_fail <= 1'b1;
                            state       <= IDLE;
                            sh          <= '0;
                            bit_cnt     <= '0;
                        end else if (word_done) begin
                            rnd_data  <= {sh[WORD_W-2:0], raw_bit};
                            rnd_valid <= 1'b1;
                            state     <= HOLD;
                            sh        <= '0;
                            bit_cnt   <= '0;
                        end else begin
                            sh      <= {sh[WORD_W-2:0], raw_bit};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            state   <= CRST;
                        end
                    end
                    HOLD: begin
                        if (rnd_ready) begin
                            rnd_valid <= 1'b0;
                            cnt       <= '0;
                            state     <= en ? CRST : IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trng_osc_sampler.sv
// Randomized bench for trng_osc_sampler against a bit-schedule and repetition-run model.
module tb_trng_osc_sampler;

    localparam int N_CELLS   = 4;
    localparam int WORD_W    = 32;
    localparam int RST_CYC   = 4;
    localparam int OSC_CYC   = 16;
    localparam int REP_LIMIT = 32;
    localparam int PERIOD    = RST_CYC + OSC_CYC + 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic [N_CELLS-1:0] osc_in;
    logic               cell_t;
    logic               cell_i1;
    logic               cell_i2;
    logic [WORD_W-1:0]  rnd_data;
    logic               rnd_valid;
    logic               rnd_ready;
    logic               health_fail;

    int                 checks = 0;
    int                 errors = 0;
    int                 run_len = 0;
    logic               run_bit = 1'b0;
    logic [WORD_W-1:0]  last_pat = '0;

    always #5 clk = ~clk;

    trng_osc_sampler #(
        .N_CELLS(N_CELLS), .WORD_W(WORD_W), .RST_CYC(RST_CYC),
        .OSC_CYC(OSC_CYC), .REP_LIMIT(REP_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .osc_in(osc_in),
        .cell_t(cell_t), .cell_i1(cell_i1), .cell_i2(cell_i2),
        .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .health_fail(health_fail)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random cell outputs whose XOR equals the wanted raw bit.
    function automatic logic [N_CELLS-1:0] osc_with_parity(input logic b);
        logic [N_CELLS-1:0] v;
        v = N_CELLS'($urandom);
        if ((^v) != b) v[0] = ~v[0];
        return v;
    endfunction

    // Length of the current run of identical raw bits; returns 1 when the limit is reached.
    function automatic bit model_sample(input logic b);
        if (run_len > 0 && b == run_bit) run_len++;
        else run_len = 1;
        run_bit = b;
        return run_len >= REP_LIMIT;
    endfunction

    task automatic sample_step(input logic b, output bit failed);
        failed = model_sample(b);
        if (failed) begin
            check_eq("hf_set", 64'(health_fail), 64'd1);
            for (int i = 0; i < 30; i++) begin
                tick();
                check_eq("hf_cell_t", 64'(cell_t), 64'd0);
                check_eq("hf_valid", 64'(rnd_valid), 64'd0);
                check_eq("hf_sticky", 64'(health_fail), 64'd1);
            end
        end else begin
            check_eq("hf_clear", 64'(health_fail), 64'd0);
        end
    endtask

    // The first tick is the edge that enters CRST (from IDLE, or the HOLD handshake edge).
    task automatic run_word(input logic [WORD_W-1:0] pat, input int abort_bit);
        bit failed;
        osc_in = osc_with_parity(pat[WORD_W-1]);
        for (int j = 0; j < WORD_W; j++) begin
            for (int k = 0; k < PERIOD; k++) begin
                if (j == abort_bit && k == RST_CYC + 4) begin
                    en = 1'b0;
                    tick();
                    check_eq("abort_cell_t", 64'(cell_t), 64'd0);
                    check_eq("abort_valid", 64'(rnd_valid), 64'd0);
                    return;
                end
                tick();
                rnd_ready = 1'b0;
                check_eq("cell_t", 64'(cell_t), 64'(k >= RST_CYC));
                check_eq("cell_i1", 64'(cell_i1), 64'(k >= RST_CYC));
                check_eq("cell_i2", 64'(cell_i2), 64'd0);
                check_eq("valid_low", 64'(rnd_valid), 64'd0);
                if (k == 0 && j > 0) begin
                    sample_step(pat[WORD_W-j], failed);
                    if (failed) return;
                    osc_in = osc_with_parity(pat[WORD_W-1-j]);
                end
            end
        end
        tick();
        sample_step(pat[0], failed);
        if (failed) return;
        check_eq("valid_high", 64'(rnd_valid), 64'd1);
        check_eq("rnd_data", 64'(rnd_data), 64'(pat));
        check_eq("hold_cell_t", 64'(cell_t), 64'd0);
        last_pat = pat;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; rnd_ready = 1'b0; osc_in = '0;
        repeat (3) tick();
        check_eq("rst_cell_t", 64'(cell_t), 64'd0);
        check_eq("rst_cell_i1", 64'(cell_i1), 64'd0);
        check_eq("rst_valid", 64'(rnd_valid), 64'd0);
        check_eq("rst_data", 64'(rnd_data), 64'd0);
        check_eq("rst_hf", 64'(health_fail), 64'd0);

        // Reset asserted while the cells are free-running.
        rst_n = 1'b1; en = 1'b1;
        repeat (10) tick();
        check_eq("run_cell_t", 64'(cell_t), 64'd1);
        rst_n = 1'b0;
        tick();
        check_eq("midrst_cell_t", 64'(cell_t), 64'd0);
        check_eq("midrst_cell_i1", 64'(cell_i1), 64'd0);
        check_eq("midrst_cell_i2", 64'(cell_i2), 64'd0);
        check_eq("midrst_valid", 64'(rnd_valid), 64'd0);
        check_eq("midrst_hf", 64'(health_fail), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1; en = 1'b0; run_len = 0;
        repeat (2) tick();
        check_eq("idle_cell_t", 64'(cell_t), 64'd0);

        // Alternating raw bits, MSB first.
        en = 1'b1;
        run_word(32'hAAAA_AAAA, -1);
        check_eq("alt_word", 64'(rnd_data), 64'hAAAA_AAAA);

        // Back-pressure in HOLD.
        for (int i = 0; i < 100; i++) begin
            tick();
            check_eq("bp_valid", 64'(rnd_valid), 64'd1);
            check_eq("bp_data", 64'(rnd_data), 64'(last_pat));
            check_eq("bp_cell_t", 64'(cell_t), 64'd0);
        end
        rnd_ready = 1'b1;
        run_word(WORD_W'($urandom), -1);

        // en dropped in HOLD: word still handed over, then idle.
        en = 1'b0;
        repeat (3) begin
            tick();
            check_eq("hold_en0_valid", 64'(rnd_valid), 64'd1);
        end
        rnd_ready = 1'b1;
        tick();
        rnd_ready = 1'b0;
        check_eq("hold_en0_xfer", 64'(rnd_valid), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_en0_idle", 64'(cell_t), 64'd0);
            check_eq("hold_en0_vlow", 64'(rnd_valid), 64'd0);
        end

        // Abort at bit 10, then a fresh word with no stale bits.
        en = 1'b1;
        run_word(WORD_W'($urandom), 10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("abort_idle", 64'(cell_t), 64'd0);
        end
        en = 1'b1;
        run_word(WORD_W'($urandom), -1);

        for (int w = 0; w < 2; w++) begin
            repeat ($urandom_range(0, 5)) begin
                tick();
                check_eq("wait_valid", 64'(rnd_valid), 64'd1);
            end
            rnd_ready = 1'b1;
            run_word(WORD_W'($urandom), -1);
        end

        // Reset while a word is pending loses it.
        rst_n = 1'b0; en = 1'b0;
        tick();
        check_eq("hold_rst_valid", 64'(rnd_valid), 64'd0);
        check_eq("hold_rst_data", 64'(rnd_data), 64'd0);
        rst_n = 1'b1; run_len = 0;

        // Stuck source: failure on the 32nd sample, which also completes the word.
        en = 1'b1;
        run_word('0, -1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("stuck_cell_t", 64'(cell_t), 64'd0);
            check_eq("stuck_valid", 64'(rnd_valid), 64'd0);
            check_eq("stuck_hf", 64'(health_fail), 64'd1);
        end
        rst_n = 1'b0;
        tick();
        check_eq("hf_rst", 64'(health_fail), 64'd0);
        rst_n = 1'b1; en = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
